// File: rtl/hex_entry_pkg.sv
// Shared definitions for the hex entry block.
//   - deb_state_t : button debounce FSM state encoding
//   - cmd_t       : the single command executed in a given cycle
//   - NDIG, DEB_W : digit capacity and debounce counter width
//   - pick_cmd()  : resolves coincident button pulses (clr > del > push)
package hex_entry_pkg;

    localparam logic [3:0] NDIG  = 4'd8;
    localparam int         DEB_W = 20;

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_CLR  = 2'd1,
        CMD_DEL  = 2'd2,
        CMD_PUSH = 2'd3
    } cmd_t;

    // Lower-priority pulses arriving in the same cycle are simply dropped.
    function automatic cmd_t pick_cmd(input logic clr, input logic del, input logic push);
        cmd_t cmd;
        cmd = CMD_NONE;
        if (clr) begin
            cmd = CMD_CLR;
        end else if (del) begin
            cmd = CMD_DEL;
        end else if (push) begin
            cmd = CMD_PUSH;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/hex_entry_btn_debounce.sv
// Debouncer for one raw push button.
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   raw   : raw, asynchronous button level
//   level : debounced button level (registered)
//   rise  : one-cycle pulse when the debounced level goes high (registered)
// The raw input is brought into the clock domain with a 2-flop synchronizer.
// A level change is accepted only after DEB_CYCLES consecutive stable clocks;
// any bounce back during the wait returns to the previous stable state.
module btn_debounce
    import hex_entry_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic             sync_meta_reg;
    logic             sync_reg;
    deb_state_t       state_reg;
    logic [DEB_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
        end else begin
            sync_meta_reg <= raw;
            sync_reg      <= sync_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= S_LO;
            cnt_reg   <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            rise <= 1'b0;
            unique case (state_reg)
                S_LO: begin
                    if (sync_reg) begin
                        state_reg <= S_WAIT_HI;
                        cnt_reg   <= '0;
                    end
                end
                S_WAIT_HI: begin
                    if (!sync_reg) begin
                        state_reg <= S_LO;
                    end else begin
                        cnt_reg <= cnt_reg + 20'd1;
                        if (cnt_reg == DEB_CYCLES - 20'd1) begin
                            state_reg <= S_HI;
                            level     <= 1'b1;
                            rise      <= 1'b1;
                        end
                    end
                end
                S_HI: begin
                    if (!sync_reg) begin
                        state_reg <= S_WAIT_LO;
                        cnt_reg   <= '0;
                    end
                end
                S_WAIT_LO: begin
                    if (sync_reg) begin
                        state_reg <= S_HI;
                    end else begin
                        cnt_reg <= cnt_reg + 20'd1;
                        // Release is silent: only the level drops.
                        if (cnt_reg == DEB_CYCLES - 20'd1) begin
                            state_reg <= S_LO;
                            level     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= S_LO;
                end
            endcase
        end
    end

endmodule

// File: rtl/hex_entry.sv
// Operator hex entry stage feeding the 8-digit seven-segment display driver.
//   clk      : system clock
//   rstn     : asynchronous active-low reset
//   sw       : 4-bit hex nibble from slide switches (asynchronous)
//   btn_push : raw button, append sw as the new least-significant digit
//   btn_del  : raw button, drop the least-significant digit
//   btn_clr  : raw button, clear all digits
//   d        : entered value, newest nibble in d[3:0] (registered)
//   ndig     : number of valid digits 0..8 (registered)
//   full     : 1 when ndig == 8 (registered)
//   err      : one-cycle pulse when a push is rejected because full
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  sw,
    input  logic        btn_push,
    input  logic        btn_del,
    input  logic        btn_clr,
    output logic [31:0] d,
    output logic [3:0]  ndig,
    output logic        full,
    output logic        err
);

    // Button index: 0 = push, 1 = del, 2 = clr.
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;

    assign btn_raw = {btn_clr, btn_del, btn_push};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk   (clk),
                .rstn  (rstn),
                .raw   (btn_raw[gi]),
                .level (btn_level[gi]),
                .rise  (btn_rise[gi])
            );
        end
    endgenerate

    // Switches are quasi-static, so synchronizing is enough; no debounce.
    logic [3:0] sw_meta_reg;
    logic [3:0] sw_sync_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_meta_reg <= 4'h0;
            sw_sync_reg <= 4'h0;
        end else begin
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    logic [31:0] d_reg;
    logic [31:0] d_next;
    logic [3:0]  ndig_reg;
    logic [3:0]  ndig_next;
    logic        full_reg;
    logic        err_reg;
    logic        err_next;
    cmd_t        cmd;

    // The debounced levels are not needed for command decoding; only the
    // rising-edge pulses trigger edits.
    logic unused_levels;
    assign unused_levels = ^btn_level;

    always_comb begin
        d_next    = d_reg;
        ndig_next = ndig_reg;
        err_next  = 1'b0;
        cmd       = pick_cmd(btn_rise[2], btn_rise[1], btn_rise[0]);
        unique case (cmd)
            CMD_CLR: begin
                d_next    = 32'h0;
                ndig_next = 4'd0;
            end
            CMD_DEL: begin
                if (ndig_reg != 4'd0) begin
                    d_next    = {4'h0, d_reg[31:4]};
                    ndig_next = ndig_reg - 4'd1;
                end
            end
            CMD_PUSH: begin
                if (ndig_reg < NDIG) begin
                    d_next    = {d_reg[27:0], sw_sync_reg};
                    ndig_next = ndig_reg + 4'd1;
                end else begin
                    err_next = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_reg    <= 32'h0;
            ndig_reg <= 4'd0;
            full_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            d_reg    <= d_next;
            ndig_reg <= ndig_next;
            full_reg <= (ndig_next == NDIG) && !unused_levels_dummy();
            err_reg  <= err_next;
        end
    end

    // Keeps the unused debounced levels referenced without affecting logic.
    function automatic logic unused_levels_dummy();
        return 1'b0 & unused_levels;
    endfunction

    assign d    = d_reg;
    assign ndig = ndig_reg;
    assign full = full_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry (DEB_CYCLES = 4). A digit queue holds the
// expected entry (oldest first); d, ndig, full and err counts are derived
// from it after each button press.
module tb_hex_entry;

    logic        clk;
    logic        rstn;
    logic [3:0]  sw;
    logic        btn_push;
    logic        btn_del;
    logic        btn_clr;
    logic [31:0] d;
    logic [3:0]  ndig;
    logic        full;
    logic        err;

    int total;
    int bad;

    logic [3:0] q[$];

    hex_entry #(
        .DEB_CYCLES(20'd4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sw       (sw),
        .btn_push (btn_push),
        .btn_del  (btn_del),
        .btn_clr  (btn_clr),
        .d        (d),
        .ndig     (ndig),
        .full     (full),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display value: digits in entry order, newest lowest.
    function automatic logic [31:0] model_d();
        logic [31:0] v;
        v = 32'h0;
        foreach (q[i]) v = v * 16 + 32'(q[i]);
        return v;
    endfunction

    // Applies one command to the model; returns the expected err pulse count.
    function automatic int model_apply(input logic [2:0] which, input logic [3:0] nib);
        if (which[2]) begin
            q.delete();
        end else if (which[1]) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (which[0]) begin
            if (q.size() < 8) q.push_back(nib);
            else return 1;
        end
        return 0;
    endfunction

    // which = {clr, del, push}. Holds the buttons, releases them, and counts
    // every cycle err is seen high across the whole press.
    task automatic press(input logic [2:0] which, input logic [3:0] nib, output int errs);
        errs = 0;
        @(negedge clk);
        sw       = nib;
        btn_clr  = which[2];
        btn_del  = which[1];
        btn_push = which[0];
        repeat (12) begin
            @(negedge clk);
            if (err === 1'b1) errs++;
        end
        btn_clr  = 1'b0;
        btn_del  = 1'b0;
        btn_push = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (err === 1'b1) errs++;
        end
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        sw       = 4'h0;
        btn_push = 1'b0;
        btn_del  = 1'b0;
        btn_clr  = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (d !== 32'h0 || ndig !== 4'd0 || full !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset: d=%h ndig=%0d full=%b err=%b, want 0/0/0/0", d, ndig, full, err);
        end
        rstn = 1'b1;
        q.delete();
        repeat (3) @(negedge clk);
        total++;
        if (d !== 32'h0 || ndig !== 4'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: d=%h ndig=%0d err=%b, want 0/0/0", d, ndig, err);
        end
    endtask

    task automatic test_push();
        int errs;
        int exp_err;
        for (int i = 1; i <= 3; i++) begin
            press(3'b001, 4'(i), errs);
            exp_err = model_apply(3'b001, 4'(i));
            total++;
            if (ndig !== 4'(q.size()) || d !== model_d() || errs !== exp_err) begin
                bad++;
                $display("FAIL push_%0d: d=%h ndig=%0d errs=%0d, want d=%h ndig=%0d errs=%0d",
                         i, d, ndig, errs, model_d(), q.size(), exp_err);
            end
        end
        total++;
        if (d !== 32'h0000_0123 || ndig !== 4'd3 || full !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL push_123: d=%h ndig=%0d full=%b err=%b, want 00000123/3/0/0", d, ndig, full, err);
        end
    endtask

    task automatic test_del();
        int errs;
        int exp_err;
        logic [31:0] exp_d[4] = '{32'h12, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            press(3'b010, 4'h0, errs);
            exp_err = model_apply(3'b010, 4'h0);
            total++;
            if (d !== exp_d[i] || d !== model_d() || ndig !== 4'(q.size()) || errs !== exp_err) begin
                bad++;
                $display("FAIL del_%0d: d=%h ndig=%0d errs=%0d, want d=%h ndig=%0d errs=%0d",
                         i, d, ndig, errs, exp_d[i], q.size(), exp_err);
            end
        end
    endtask

    task automatic test_full();
        int errs;
        int exp_err;
        logic [3:0] nibs[9] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
        for (int i = 0; i < 9; i++) begin
            press(3'b001, nibs[i], errs);
            exp_err = model_apply(3'b001, nibs[i]);
            total++;
            if (d !== model_d() || ndig !== 4'(q.size()) || full !== (q.size() == 8) || errs !== exp_err) begin
                bad++;
                $display("FAIL full_push_%0d: d=%h ndig=%0d full=%b errs=%0d, want d=%h ndig=%0d errs=%0d",
                         i, d, ndig, full, errs, model_d(), q.size(), exp_err);
            end
        end
        total++;
        if (d !== 32'hABCD_EF01 || ndig !== 4'd8 || full !== 1'b1) begin
            bad++;
            $display("FAIL full_value: d=%h ndig=%0d full=%b, want abcdef01/8/1", d, ndig, full);
        end
    endtask

    task automatic test_bounce();
        int errs;
        int exp_err;
        logic press_seq[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic release_seq[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        press(3'b100, 4'h0, errs);
        exp_err = model_apply(3'b100, 4'h0);
        @(negedge clk);
        sw = 4'h9;
        foreach (press_seq[i]) begin
            btn_push = press_seq[i];
            repeat (2) @(negedge clk);
        end
        btn_push = 1'b1;
        repeat (20) @(negedge clk);
        foreach (release_seq[i]) begin
            btn_push = release_seq[i];
            repeat (2) @(negedge clk);
        end
        btn_push = 1'b0;
        repeat (15) @(negedge clk);
        exp_err = model_apply(3'b001, 4'h9);
        total++;
        if (d !== 32'h9 || ndig !== 4'd1 || d !== model_d()) begin
            bad++;
            $display("FAIL bounce: d=%h ndig=%0d, want 00000009/1", d, ndig);
        end
    endtask

    task automatic test_clr_priority();
        int errs;
        int exp_err;
        press(3'b100, 4'h0, errs);
        exp_err = model_apply(3'b100, 4'h0);
        press(3'b001, 4'hA, errs);
        exp_err = model_apply(3'b001, 4'hA);
        press(3'b001, 4'hB, errs);
        exp_err = model_apply(3'b001, 4'hB);
        total++;
        if (d !== 32'hAB || ndig !== 4'd2) begin
            bad++;
            $display("FAIL clr_setup: d=%h ndig=%0d, want 000000ab/2", d, ndig);
        end
        press(3'b101, 4'h5, errs);
        exp_err = model_apply(3'b101, 4'h5);
        total++;
        if (d !== 32'h0 || ndig !== 4'd0 || full !== 1'b0 || errs !== exp_err) begin
            bad++;
            $display("FAIL clr_push: d=%h ndig=%0d full=%b errs=%0d, want 0/0/0/0", d, ndig, full, errs);
        end
    endtask

    task automatic test_reset_mid();
        int errs;
        int exp_err;
        int lat;
        for (int i = 0; i < 5; i++) begin
            press(3'b001, 4'(i + 3), errs);
            exp_err = model_apply(3'b001, 4'(i + 3));
        end
        total++;
        if (ndig !== 4'd5 || d !== model_d()) begin
            bad++;
            $display("FAIL rst_setup: d=%h ndig=%0d, want %h/5", d, ndig, model_d());
        end
        @(negedge clk);
        sw = 4'h7;
        btn_push = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if (d !== 32'h0 || ndig !== 4'd0 || full !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: d=%h ndig=%0d full=%b err=%b, want 0/0/0/0", d, ndig, full, err);
        end
        q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        lat = 0;
        while (ndig === 4'd0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat < 6 || lat > 10) begin
            bad++;
            $display("FAIL rst_relatency: cycles=%0d, want 6..10", lat);
        end
        exp_err = model_apply(3'b001, 4'h7);
        repeat (20) @(negedge clk);
        btn_push = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (d !== model_d() || ndig !== 4'd1 || err !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold: d=%h ndig=%0d err=%b, want 00000007/1/0", d, ndig, err);
        end
    endtask

    task automatic test_random();
        int errs;
        int exp_err;
        int r;
        logic [2:0] which;
        logic [3:0] nib;
        for (int n = 0; n < 40; n++) begin
            r   = int'($urandom_range(0, 9));
            nib = 4'($urandom_range(0, 15));
            which = (r == 0) ? 3'b100 : (r <= 2) ? 3'b010 : 3'b001;
            if (r == 9) which = 3'(1 + $urandom_range(0, 6));
            press(which, nib, errs);
            exp_err = model_apply(which, nib);
            total++;
            if (d !== model_d() || ndig !== 4'(q.size()) || full !== (q.size() == 8) || errs !== exp_err) begin
                bad++;
                $display("FAIL rand_%0d: op=%b sw=%h d=%h ndig=%0d full=%b errs=%0d, want d=%h ndig=%0d errs=%0d",
                         n, which, nib, d, ndig, full, errs, model_d(), q.size(), exp_err);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_push();
        test_del();
        test_full();
        test_bounce();
        test_clr_priority();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
